mult16_rr_scheduler: RTL
========================

// Module: mult16_rr_scheduler
// PURPOSE
//  Shares one combinational multiplier_16bits_version0 among NUM_REQ requesters.
//  Arbitrates round-robin, registers operands, registers the 32-bit product, and returns it tagged with the requester ID.
//  Sits between client blocks and the multiplier datapath.
//  Sustains one multiply per cycle with backpressure.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  ID_W     2  requester ID width, = $clog2(NUM_REQ)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            asynchronous active-low reset
//  req_valid    in   NUM_REQ      per-requester operand valid
//  req_ready    out  NUM_REQ      per-requester accept, one-hot or zero
//  req_a        in   16*NUM_REQ   operand A, requester i at [16*i+:16]
//  req_b        in   16*NUM_REQ   operand B, requester i at [16*i+:16]
//  rsp_valid    out  1            product valid
//  rsp_ready    in   1            consumer accepts product
//  rsp_id       out  ID_W         index of requester that issued this product
//  rsp_product  out  32           unsigned product A*B
//  busy         out  1            s1_valid | rsp_valid
//  op_count     out  16           completed responses, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - rsp_valid=0, rsp_id=0, rsp_product=0, op_count=0, busy=0.
//   - s1_valid=0, s1 data=0, rr_ptr=0.
//   - req_ready=0 while in reset.
//  Pipeline: stage S1 (s1_a, s1_b, s1_id, s1_valid) feeds the multiplier; stage S2 is the rsp_* registers.
//  Advance and accept:
//   - adv2 = !rsp_valid | rsp_ready
//   - acc1 = !s1_valid | adv2
//  Arbitration:
//   - grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready[i] = acc1 & grant[i]; at most one bit high.
//   - req_ready may depend on req_valid. req_valid must not depend on req_ready.
//  Handshake:
//   - Handshake when req_valid[i] & req_ready[i] at a rising edge.
//   - On handshake: S1 <= {a_i, b_i, i}, s1_valid <= 1, rr_ptr <= (i+1) mod NUM_REQ.
//   - With no handshake and acc1: s1_valid <= 0. rr_ptr holds.
//  S2 update: when adv2, rsp_valid <= s1_valid. If s1_valid also, rsp_product <= s1_a*s1_b and rsp_id <= s1_id.
//  Latency and throughput:
//   - Handshake at edge T gives rsp_valid=1 after edge T+1, with no stall.
//   - Back-to-back accepts give one product per cycle.
//  Stall: rsp_valid & !rsp_ready holds S2. If S1 is also full, S1 holds and req_ready=0.
//  op_count increments on rsp_valid & rsp_ready and wraps.
//  Width: unsigned 16x16->32, exact; no truncation.
//  Edge cases:
//   - Requester holding req_valid with no ready keeps its operands stable; it is served within NUM_REQ accepts.
//   - A requester that is the only valid one is granted every cycle (rr_ptr skips empty slots).
//   - New handshake in the same cycle S2 drains is legal; no bubble.
//   - Reset mid-operation drops in-flight S1/S2 data silently. No response is issued for it.
//   - rsp_id / rsp_product are don't-care while rsp_valid=0. They hold their last value.
// STRUCTURE
//  Shared include mult_defs.vh:
//   - MULT_W=16, PROD_W=32.
//   - Default NUM_REQ.
//  Sub-module rr_arbiter #(NUM_REQ): combinational round-robin grant from req_valid and rr_ptr, plus the pointer register.
//  One instance of multiplier_16bits_version0 (ports product, A, B) on the S1 outputs.
// TESTING
//  1. Reset hold, then single op:
//   - Stimulus: req0 A=10097, B=3943, rsp_ready=1.
//   - Response: req_ready[0]=1 for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_product=39812471, op_count=1.
//  2. All four requesters valid from the same cycle, rsp_ready=1:
//   - Grants in order 0,1,2,3, one per cycle.
//   - Responses in order 0,1,2,3 with correct products, consecutive cycles.
//  3. Backpressure:
//   - Stimulus: rsp_ready=0 for 5 cycles with req1 continuously valid.
//   - Response: exactly 2 accepts (S1 and S2 filled), then req_ready=0. rsp_* stable while stalled.
//   - Release rsp_ready: all products delivered in order, no loss or duplication.
//  4. Extremes:
//   - 65535*65535 gives 4294836225.
//   - 40960*1 gives 40960.
//   - 0*65535 gives 0.
//  5. Reset mid-operation: assert rst_n=0 with S1 and S2 both full.
//   - Immediately rsp_valid=0, op_count=0, rr_ptr=0.
//   - After release, no stale response appears.
//  6. op_count wrap: 65536 completed ops leave op_count=0.

Source files
------------

// File: rtl/mult16_rr_scheduler_pkg.sv
// mult16_rr_scheduler_pkg: shared widths and defaults for the shared-multiplier scheduler
package mult16_rr_scheduler_pkg;
    localparam int MULT_W      = 16;
    localparam int PROD_W      = 32;
    localparam int DEF_NUM_REQ = 4;
    typedef logic [MULT_W-1:0] opnd_t;
    typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/mult16_rr_scheduler_arb.sv
// rr_arbiter: round-robin grant starting at rr_ptr, pointer moves past each winner
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               take,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);
    logic [ID_W-1:0] rr_ptr;
    // scan downwards so the slot closest to rr_ptr wins last
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                gnt_any = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= '0;
        else if (take) rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
endmodule

// File: rtl/multiplier_16bits_version0.sv
// multiplier_16bits_version0: combinational unsigned 16x16->32 multiplier
module multiplier_16bits_version0
    import mult16_rr_scheduler_pkg::*;
(
    output logic [PROD_W-1:0] product,
    input  logic [MULT_W-1:0] A,
    input  logic [MULT_W-1:0] B
);
    assign product = PROD_W'(A) * PROD_W'(B);
endmodule

// File: rtl/mult16_rr_scheduler.sv
// mult16_rr_scheduler: round-robin sharing of one multiplier with a two-stage backpressured pipe
module mult16_rr_scheduler
    import mult16_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [MULT_W*NUM_REQ-1:0] req_a,
    input  logic [MULT_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [PROD_W-1:0]         rsp_product,
    output logic                      busy,
    output logic [15:0]               op_count
);
    logic            s1_valid, adv2, acc1, hs, gnt_any;
    opnd_t           s1_a, s1_b;
    prod_t           prod;
    logic [ID_W-1:0] s1_id, gnt_id;
    assign adv2      = !rsp_valid || rsp_ready;
    assign acc1      = !s1_valid || adv2;
    // rst_n gates the handshake so nothing is offered while held in reset
    assign hs        = acc1 && gnt_any && rst_n;
    assign req_ready = hs ? NUM_REQ'(1) << gnt_id : '0;
    assign busy      = s1_valid | rsp_valid;
    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .take(hs), .gnt_id(gnt_id), .gnt_any(gnt_any)
    );
    multiplier_16bits_version0 u_mul (.product(prod), .A(s1_a), .B(s1_b));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (acc1) begin
            s1_valid <= hs;
            if (hs) begin
                s1_a  <= req_a[MULT_W*int'(gnt_id) +: MULT_W];
                s1_b  <= req_b[MULT_W*int'(gnt_id) +: MULT_W];
                s1_id <= gnt_id;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            op_count    <= '0;
        end else begin
            if (adv2) begin
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_product <= prod;
                    rsp_id      <= s1_id;
                end
            end
            if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
        end
    end
endmodule
